hit_judge: RTL and testbench
============================

HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameters: SETTLE_CYCLES, 2, game_clock cycles waited after a frame change before sampling the note.
REQ-002 Parameters: SCORE_PER_HIT, 10, points per correct hit.
REQ-003 Parameters: COMBO_BONUS_AT, 8, combo count at or above which each hit scores 2*SCORE_PER_HIT.
REQ-004 Ports: game_clock  in  1  sole clock, all state on posedge.
REQ-005 Ports: game_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 Ports: game_frame  in  8  current beat count from the frame counter, unsigned.
REQ-007 Ports: curr_note  in  12  one-hot note from the note engine; all-zero means rest.
REQ-008 Ports: hold_length  in  4  beats of the current note from the note engine.
REQ-009 Ports: keys  in  12  raw player keys, asynchronous, active-high, bit n = note n.
REQ-010 Ports: score  out  16  accumulated score.
REQ-011 Ports: combo  out  8  consecutive hits.
REQ-012 Ports: max_combo  out  8  highest combo since reset.
REQ-013 Ports: hit_pulse / miss_pulse / stray_pulse  out  1 each  one-cycle judgment strobes.
REQ-014 Ports: target_note  out  12  latched note under judgment.
REQ-015 Ports: judge_state  out  3  state encoding (IDLE=0, SETTLE=1, ARMED=2, HIT=3, DONE=4, REST=5).

Function
REQ-016 keys SHALL pass a 2-flop synchronizer, then a rising-edge detector (press_edge); the pulse follows a key edge by 3 cycles.
REQ-017 frame_tick SHALL assert for one cycle when game_frame differs from its value registered on the previous cycle.
REQ-018 restart SHALL be frame_tick with game_frame==0; it clears score and combo, keeps max_combo, and forces SETTLE.
REQ-019 IDLE: on frame_tick -> SETTLE.
REQ-020 SETTLE: wait SETTLE_CYCLES cycles, then latch target_note=curr_note and beats_left=hold_length (0 loads 1); target 0 -> REST, else -> ARMED.
REQ-021 ARMED: press_edge with any bit outside target_note -> miss_pulse, combo=0, -> DONE; else press_edge&target_note nonzero -> hit_pulse, -> HIT.
REQ-022 ARMED: a correct and a wrong edge in the same cycle SHALL judge as miss.
REQ-023 HIT/DONE: further press_edge is ignored.
REQ-024 REST: any press_edge -> stray_pulse; score and combo are unaffected.
REQ-025 On frame_tick in ARMED/HIT/DONE/REST: if beats_left==1, close the window and -> SETTLE, else decrement beats_left.
REQ-026 A window closing from ARMED SHALL emit miss_pulse and clear combo in that cycle.
REQ-027 Hit: combo+=1, saturating at 255; score += SCORE_PER_HIT, or 2*SCORE_PER_HIT if pre-increment combo>=COMBO_BONUS_AT.
REQ-028 score SHALL saturate at 16'hFFFF.
REQ-029 max_combo SHALL update the cycle after combo exceeds it.
REQ-030 A press_edge and a window-closing frame_tick in the same cycle: the press is judged first, then the window closes.
REQ-031 frame_tick during SETTLE SHALL restart the settle count without a judgment.
REQ-032 At most one of hit_pulse, miss_pulse or stray_pulse SHALL assert per cycle, except REQ-030 (hit then close emits no miss).

Reset
REQ-033 game_reset_n low SHALL immediately force: state IDLE, score 0, combo 0, max_combo 0, target_note 0, all pulses 0, beats_left 0, sync/edge/frame registers 0.
REQ-034 Reset asserted mid-window SHALL discard the window with no pulse; after release, the first frame_tick enters SETTLE.

Verification
REQ-035 Bench: frame 0->1, curr_note=12'h001, hold 1; keys[0] rises 5 cycles after settle -> hit_pulse once, score 10, combo 1.
REQ-036 Bench: same note, no key, next frame_tick -> miss_pulse, combo 0, score unchanged.
REQ-037 Bench: curr_note=12'h080, keys[7] and keys[2] rise together -> miss_pulse only, state DONE.
REQ-038 Bench: 9 consecutive hits -> 9th adds 20, score 100, combo 9, max_combo 9.
REQ-039 Bench: rest (curr_note 0) with key press -> stray_pulse, score/combo unchanged; hold 2 note spans two ticks before re-SETTLE.
REQ-040 Bench: game_reset_n low mid-ARMED -> all outputs 0 same cycle; game_frame wrap 255->0 -> score and combo cleared, max_combo kept.

Source files
------------

// File: rtl/hit_judge.sv
// Rhythm-game judge: synchronizes player keys, tracks frame-driven note windows and
// keeps score, combo and max combo with one-cycle hit/miss/stray strobes.
module hit_judge #(
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned SCORE_PER_HIT  = 10,
   parameter int unsigned COMBO_BONUS_AT = 8
) (
   input  logic        game_clock,
   input  logic        game_reset_n,
   input  logic [7:0]  game_frame,
   input  logic [11:0] curr_note,
   input  logic [3:0]  hold_length,
   input  logic [11:0] keys,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        stray_pulse,
   output logic [11:0] target_note,
   output logic [2:0]  judge_state
);
   localparam int unsigned NOTE_W  = 12;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned COMBO_W = 8;
   localparam int unsigned BEAT_W  = 4;
   localparam int unsigned CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SCORE_W:0] HIT_PTS   = (SCORE_W + 1)'(SCORE_PER_HIT);
   localparam logic [SCORE_W:0] BONUS_PTS = (SCORE_W + 1)'(2 * SCORE_PER_HIT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_ARMED  = 3'd2,
      S_HIT    = 3'd3,
      S_DONE   = 3'd4,
      S_REST   = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [NOTE_W-1:0]   key_s1, key_s2, key_s3;
   logic [7:0]          frame_q;
   logic [CNT_W-1:0]    settle_cnt, cnt_n;
   logic [BEAT_W-1:0]   beats_left, beats_n;
   logic [NOTE_W-1:0]   target_n;
   logic [SCORE_W-1:0]  score_n;
   logic [COMBO_W-1:0]  combo_n, max_n;
   logic                hit_n, miss_n, stray_n;
   logic [SCORE_W:0]    score_sum;

   logic                frame_tick_c, restart_c, pressed_c;
   logic [NOTE_W-1:0]   press_edge_c;

   assign frame_tick_c = (game_frame != frame_q);
   assign restart_c    = frame_tick_c && (game_frame == 8'd0);
   assign press_edge_c = key_s2 & ~key_s3;
   assign pressed_c    = |press_edge_c;
   assign judge_state  = state;

   // Next-state, judgment and scoring
   always_comb begin
      state_n   = state;
      cnt_n     = settle_cnt;
      beats_n   = beats_left;
      target_n  = target_note;
      score_n   = score;
      combo_n   = combo;
      hit_n     = 1'b0;
      miss_n    = 1'b0;
      stray_n   = 1'b0;
      max_n     = (combo > max_combo) ? combo : max_combo;
      score_sum = (SCORE_W + 1)'(score) +
                  ((32'(combo) >= COMBO_BONUS_AT) ? BONUS_PTS : HIT_PTS);

      if (restart_c) begin
         state_n = S_SETTLE;
         cnt_n   = '0;
         score_n = '0;
         combo_n = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_tick_c) begin
                  state_n = S_SETTLE;
                  cnt_n   = '0;
               end
            end
            S_SETTLE: begin
               if (frame_tick_c) begin
                  cnt_n = '0;
               end else if (32'(settle_cnt) + 32'd1 >= SETTLE_CYCLES) begin
                  target_n = curr_note;
                  beats_n  = (hold_length == '0) ? BEAT_W'(1) : hold_length;
                  state_n  = (curr_note == '0) ? S_REST : S_ARMED;
               end else begin
                  cnt_n = settle_cnt + CNT_W'(1);
               end
            end
            S_ARMED: begin
               // Any off-target bit makes the whole press a miss
               if (pressed_c) begin
                  if (|(press_edge_c & ~target_note)) begin
                     miss_n  = 1'b1;
                     combo_n = '0;
                     state_n = S_DONE;
                  end else begin
                     hit_n   = 1'b1;
                     combo_n = (combo == '1) ? combo : combo + COMBO_W'(1);
                     score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                     state_n = S_HIT;
                  end
               end
            end
            S_REST: begin
               if (pressed_c) stray_n = 1'b1;
            end
            default: ;
         endcase

         // Window bookkeeping runs after the press judgment of the same cycle
         if (frame_tick_c && (state inside {S_ARMED, S_HIT, S_DONE, S_REST})) begin
            if (beats_left == BEAT_W'(1)) begin
               state_n = S_SETTLE;
               cnt_n   = '0;
               if (state == S_ARMED && !hit_n && !miss_n) begin
                  miss_n  = 1'b1;
                  combo_n = '0;
               end
            end else begin
               beats_n = beats_left - BEAT_W'(1);
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge game_clock or negedge game_reset_n) begin
      if (!game_reset_n) begin
         state       <= S_IDLE;
         key_s1      <= '0;
         key_s2      <= '0;
         key_s3      <= '0;
         frame_q     <= '0;
         settle_cnt  <= '0;
         beats_left  <= '0;
         target_note <= '0;
         score       <= '0;
         combo       <= '0;
         max_combo   <= '0;
         hit_pulse   <= 1'b0;
         miss_pulse  <= 1'b0;
         stray_pulse <= 1'b0;
      end else begin
         state       <= state_n;
         key_s1      <= keys;
         key_s2      <= key_s1;
         key_s3      <= key_s2;
         frame_q     <= game_frame;
         settle_cnt  <= cnt_n;
         beats_left  <= beats_n;
         target_note <= target_n;
         score       <= score_n;
         combo       <= combo_n;
         max_combo   <= max_n;
         hit_pulse   <= hit_n;
         miss_pulse  <= miss_n;
         stray_pulse <= stray_n;
      end
   end
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hits, misses, rests, combo bonus, restart and reset.
module tb_hit_judge;
   logic        game_clock = 1'b0;
   logic        game_reset_n = 1'b0;
   logic [7:0]  game_frame = 8'd0;
   logic [11:0] curr_note = 12'd0;
   logic [3:0]  hold_length = 4'd1;
   logic [11:0] keys = 12'd0;
   logic [15:0] score;
   logic [7:0]  combo, max_combo;
   logic        hit_pulse, miss_pulse, stray_pulse;
   logic [11:0] target_note;
   logic [2:0]  judge_state;

   int checks = 0;
   int failures = 0;

   hit_judge dut (
      .game_clock  (game_clock),
      .game_reset_n(game_reset_n),
      .game_frame  (game_frame),
      .curr_note   (curr_note),
      .hold_length (hold_length),
      .keys        (keys),
      .score       (score),
      .combo       (combo),
      .max_combo   (max_combo),
      .hit_pulse   (hit_pulse),
      .miss_pulse  (miss_pulse),
      .stray_pulse (stray_pulse),
      .target_note (target_note),
      .judge_state (judge_state)
   );

   always #5 game_clock = ~game_clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic run_cycles(input int n, output int h, output int m, output int s);
      h = 0; m = 0; s = 0;
      repeat (n) begin
         @(negedge game_clock);
         if (hit_pulse)   h++;
         if (miss_pulse)  m++;
         if (stray_pulse) s++;
      end
   endtask

   // Change the frame, then wait (bounded) through SETTLE into the next window
   task automatic next_window(input logic [7:0] f);
      @(negedge game_clock);
      game_frame = f;
      for (int i = 0; i < 10; i++) begin
         @(negedge game_clock);
         if (judge_state == 3'd1) break;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge game_clock);
         if (judge_state != 3'd1) break;
      end
   endtask

   task automatic test_reset;
      int h, m, s;
      repeat (2) @(negedge game_clock);
      checks++; if (judge_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", judge_state); end
      checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
      checks++; if (combo !== 8'd0 || max_combo !== 8'd0) begin failures++; $display("FAIL reset_combo got=%0d/%0d exp=0/0", combo, max_combo); end
      checks++; if (target_note !== 12'd0) begin failures++; $display("FAIL reset_target got=%h exp=000", target_note); end
      game_reset_n = 1'b1;
      run_cycles(3, h, m, s);
      checks++; if (judge_state !== 3'd0 || h + m + s != 0) begin failures++; $display("FAIL idle_hold got state=%0d pulses=%0d exp state=0 pulses=0", judge_state, h + m + s); end
   endtask

   task automatic test_hit;
      int h, m, s;
      curr_note = 12'h001; hold_length = 4'd1;
      next_window(8'd1);
      checks++; if (judge_state !== 3'd2 || target_note !== 12'h001) begin failures++; $display("FAIL armed got state=%0d target=%h exp state=2 target=001", judge_state, target_note); end
      run_cycles(5, h, m, s);
      keys = 12'h001;
      run_cycles(6, h, m, s);
      keys = 12'h000;
      checks++; if (h != 1 || m != 0 || s != 0) begin failures++; $display("FAIL hit_pulses got h=%0d m=%0d s=%0d exp 1/0/0", h, m, s); end
      checks++; if (score !== 16'd10 || combo !== 8'd1) begin failures++; $display("FAIL hit_score got score=%0d combo=%0d exp 10/1", score, combo); end
      checks++; if (judge_state !== 3'd3) begin failures++; $display("FAIL hit_state got=%0d exp=3", judge_state); end
   endtask

   task automatic test_miss_timeout;
      int h, m, s;
      next_window(8'd2);
      checks++; if (judge_state !== 3'd2) begin failures++; $display("FAIL rearm got=%0d exp=2", judge_state); end
      @(negedge game_clock);
      game_frame = 8'd3;
      run_cycles(3, h, m, s);
      checks++; if (m != 1 || h != 0) begin failures++; $display("FAIL timeout_pulses got m=%0d h=%0d exp 1/0", m, h); end
      checks++; if (combo !== 8'd0 || score !== 16'd10 || max_combo !== 8'd1) begin failures++; $display("FAIL timeout_regs got combo=%0d score=%0d max=%0d exp 0/10/1", combo, score, max_combo); end
   endtask

   task automatic test_wrong_key;
      int h, m, s;
      curr_note = 12'h080;
      next_window(8'd4);
      checks++; if (target_note !== 12'h080) begin failures++; $display("FAIL wrong_target got=%h exp=080", target_note); end
      keys = 12'h084;
      run_cycles(6, h, m, s);
      keys = 12'h000;
      checks++; if (m != 1 || h != 0 || s != 0) begin failures++; $display("FAIL wrong_pulses got h=%0d m=%0d s=%0d exp 0/1/0", h, m, s); end
      checks++; if (judge_state !== 3'd4 || combo !== 8'd0 || score !== 16'd10) begin failures++; $display("FAIL wrong_regs got state=%0d combo=%0d score=%0d exp 4/0/10", judge_state, combo, score); end
      run_cycles(3, h, m, s);
   endtask

   task automatic test_combo;
      int h, m, s, total;
      total = 0;
      curr_note = 12'h001;
      next_window(8'd0);
      checks++; if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd1) begin failures++; $display("FAIL restart_regs got score=%0d combo=%0d max=%0d exp 0/0/1", score, combo, max_combo); end
      for (int i = 0; i < 9; i++) begin
         if (i > 0) next_window(8'(i));
         keys = 12'h001;
         run_cycles(5, h, m, s);
         total += h;
         keys = 12'h000;
         run_cycles(3, h, m, s);
         if (i == 7) begin
            checks++; if (score !== 16'd80 || combo !== 8'd8) begin failures++; $display("FAIL combo8 got score=%0d combo=%0d exp 80/8", score, combo); end
         end
      end
      checks++; if (total != 9) begin failures++; $display("FAIL combo_hits got=%0d exp=9", total); end
      checks++; if (score !== 16'd100 || combo !== 8'd9 || max_combo !== 8'd9) begin failures++; $display("FAIL combo9 got score=%0d combo=%0d max=%0d exp 100/9/9", score, combo, max_combo); end
   endtask

   task automatic test_rest;
      int h, m, s;
      curr_note = 12'h000; hold_length = 4'd2;
      next_window(8'd9);
      checks++; if (judge_state !== 3'd5 || target_note !== 12'h000) begin failures++; $display("FAIL rest_state got state=%0d target=%h exp 5/000", judge_state, target_note); end
      keys = 12'h008;
      run_cycles(6, h, m, s);
      keys = 12'h000;
      checks++; if (s != 1 || h != 0 || m != 0) begin failures++; $display("FAIL stray_pulses got h=%0d m=%0d s=%0d exp 0/0/1", h, m, s); end
      checks++; if (score !== 16'd100 || combo !== 8'd9) begin failures++; $display("FAIL stray_regs got score=%0d combo=%0d exp 100/9", score, combo); end
      @(negedge game_clock);
      game_frame = 8'd10;
      run_cycles(3, h, m, s);
      checks++; if (judge_state !== 3'd5) begin failures++; $display("FAIL hold2_first got=%0d exp=5", judge_state); end
      @(negedge game_clock);
      game_frame = 8'd11; hold_length = 4'd1;
      @(negedge game_clock);
      checks++; if (judge_state !== 3'd1) begin failures++; $display("FAIL hold2_second got=%0d exp=1", judge_state); end
      run_cycles(4, h, m, s);
   endtask

   task automatic test_back_to_back;
      int h, m, s;
      curr_note = 12'h001;
      next_window(8'd12);
      checks++; if (judge_state !== 3'd2) begin failures++; $display("FAIL b2b_armed got=%0d exp=2", judge_state); end
      keys = 12'h001;
      @(negedge game_clock);
      @(negedge game_clock);
      game_frame = 8'd13; curr_note = 12'h000;
      run_cycles(4, h, m, s);
      keys = 12'h000;
      checks++; if (h != 1 || m != 0) begin failures++; $display("FAIL b2b_pulses got h=%0d m=%0d exp 1/0", h, m); end
      checks++; if (score !== 16'd120 || combo !== 8'd10 || judge_state !== 3'd5) begin failures++; $display("FAIL b2b_regs got score=%0d combo=%0d state=%0d exp 120/10/5", score, combo, judge_state); end
   endtask

   task automatic test_wrap;
      int h, m, s;
      curr_note = 12'h001;
      next_window(8'd255);
      keys = 12'h001;
      run_cycles(6, h, m, s);
      keys = 12'h000;
      run_cycles(3, h, m, s);
      checks++; if (score !== 16'd140 || combo !== 8'd11 || max_combo !== 8'd11) begin failures++; $display("FAIL pre_wrap got score=%0d combo=%0d max=%0d exp 140/11/11", score, combo, max_combo); end
      @(negedge game_clock);
      game_frame = 8'd0;
      @(negedge game_clock);
      checks++; if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd11) begin failures++; $display("FAIL wrap_clear got score=%0d combo=%0d max=%0d exp 0/0/11", score, combo, max_combo); end
      checks++; if (judge_state !== 3'd1) begin failures++; $display("FAIL wrap_state got=%0d exp=1", judge_state); end
   endtask

   task automatic test_reset_mid;
      int h, m, s;
      next_window(8'd1);
      checks++; if (judge_state !== 3'd2) begin failures++; $display("FAIL mid_armed got=%0d exp=2", judge_state); end
      @(negedge game_clock);
      game_reset_n = 1'b0;
      #1;
      checks++; if (judge_state !== 3'd0 || target_note !== 12'd0) begin failures++; $display("FAIL mid_reset_state got state=%0d target=%h exp 0/000", judge_state, target_note); end
      checks++; if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0) begin failures++; $display("FAIL mid_reset_regs got score=%0d combo=%0d max=%0d exp 0/0/0", score, combo, max_combo); end
      checks++; if (hit_pulse || miss_pulse || stray_pulse) begin failures++; $display("FAIL mid_reset_pulses got %b%b%b exp 000", hit_pulse, miss_pulse, stray_pulse); end
      @(negedge game_clock);
      game_reset_n = 1'b1;
      @(negedge game_clock);
      checks++; if (judge_state !== 3'd1) begin failures++; $display("FAIL post_reset_settle got=%0d exp=1", judge_state); end
      run_cycles(4, h, m, s);
      checks++; if (judge_state !== 3'd2 || h + m + s != 0) begin failures++; $display("FAIL post_reset_arm got state=%0d pulses=%0d exp 2/0", judge_state, h + m + s); end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss_timeout();
      test_wrong_key();
      test_combo();
      test_rest();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
